// File: rtl/viterbi_ctrl.sv
// viterbi_ctrl: frame sequencer for the 4-state (K=3) Viterbi decoder.
// Steps ACS/path memory per symbol, flushes the survivors, emits decoded bits.
module viterbi_ctrl #(
   parameter int FRAME_LEN = 32,
   parameter int TAIL      = 2,
   parameter int DEPTH     = 11,
   parameter int MW        = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          frame_start,
   input  logic          sym_valid,
   input  logic [1:0]    sym_in,
   output logic          sym_ready,
   output logic          acs_en,
   output logic [1:0]    acs_sym,
   output logic          acs_erase,
   output logic          norm_en,
   input  logic [MW-1:0] pm0,
   input  logic [MW-1:0] pm1,
   input  logic [MW-1:0] pm2,
   input  logic [MW-1:0] pm3,
   input  logic [2:0]    p0,
   input  logic [2:0]    p1,
   input  logic [2:0]    p2,
   input  logic [2:0]    p3,
   output logic          dec_valid,
   output logic          dec_bit,
   output logic          frame_done,
   output logic          busy
);

   localparam int NSYM = FRAME_LEN + TAIL;
   localparam int NFL  = DEPTH - TAIL;
   localparam int CW   = $clog2(FRAME_LEN + DEPTH + 1);
   localparam int FW   = $clog2(DEPTH + 1);

   localparam logic [CW-1:0] LAST_SYM  = CW'(NSYM - 1);
   localparam logic [CW-1:0] OUT_FIRST = CW'(DEPTH);
   localparam logic [FW-1:0] FL_STEPS  = FW'(NFL);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] sc;
   logic [FW-1:0] fc;
   logic          dzero;
   logic [1:0]    best;
   logic [MW-1:0] bmin;
   logic          pbit;
   logic          unused;

   assign unused = ^{p0[1:0], p1[1:0], p2[1:0], p3[1:0]};

   // Strict compare keeps the lowest index on a tie.
   always_comb begin
      best = 2'd0;
      bmin = pm0;
      if (pm1 < bmin) begin
         best = 2'd1;
         bmin = pm1;
      end
      if (pm2 < bmin) begin
         best = 2'd2;
         bmin = pm2;
      end
      if (pm3 < bmin) begin
         best = 2'd3;
      end
      if (dzero) begin
         best = 2'd0;
      end
   end

   always_comb begin
      pbit = 1'b0;
      case (best)
         2'd0:    pbit = p0[2];
         2'd1:    pbit = p1[2];
         2'd2:    pbit = p2[2];
         default: pbit = p3[2];
      endcase
   end

   assign dec_bit = dec_valid & pbit;
   assign norm_en = acs_en & pm0[MW-1] & pm1[MW-1]
                  & pm2[MW-1] & pm3[MW-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         sc         <= '0;
         fc         <= '0;
         dzero      <= 1'b0;
         sym_ready  <= 1'b0;
         acs_en     <= 1'b0;
         acs_sym    <= 2'b00;
         acs_erase  <= 1'b0;
         dec_valid  <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         acs_en     <= 1'b0;
         acs_erase  <= 1'b0;
         acs_sym    <= 2'b00;
         frame_done <= 1'b0;
         dec_valid  <= acs_en && (sc > OUT_FIRST);
         dzero      <= acs_erase;
         unique case (state)
            IDLE: begin
               if (frame_start) begin
                  state     <= RUN;
                  sym_ready <= 1'b1;
                  busy      <= 1'b1;
                  sc        <= '0;
                  fc        <= '0;
               end
            end
            RUN: begin
               if (sym_valid && sym_ready) begin
                  acs_en  <= 1'b1;
                  acs_sym <= sym_in;
                  sc      <= sc + 1'b1;
                  if (sc == LAST_SYM) begin
                     state     <= FLUSH;
                     sym_ready <= 1'b0;
                  end
               end
            end
            FLUSH: begin
               // After the erase steps, wait until the last bit has left.
               if (fc < FL_STEPS) begin
                  acs_en    <= 1'b1;
                  acs_erase <= 1'b1;
                  sc        <= sc + 1'b1;
                  fc        <= fc + 1'b1;
               end else if (!acs_en && !dec_valid) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_viterbi_ctrl.sv
// tb_viterbi_ctrl: scoreboard bench with a behavioural K=3 ACS and
// register-exchange path memory stepped by the controller's strobes.
module tb_viterbi_ctrl;

   localparam int FL = 32;
   localparam int TL = 2;
   localparam int DP = 11;
   localparam int MW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          frame_start = 1'b0;
   logic          sym_valid = 1'b0;
   logic [1:0]    sym_in = 2'b00;
   logic          sym_ready, acs_en, acs_erase, norm_en;
   logic          dec_valid, dec_bit, frame_done, busy;
   logic [1:0]    acs_sym;
   logic [MW-1:0] pm0, pm1, pm2, pm3;
   logic [2:0]    p0, p1, p2, p3;

   int total = 0;
   int bad = 0;
   int n_dec, n_acs, n_era, n_fd;
   logic exq[$];

   logic          mdl_init = 1'b0;
   logic          ovr = 1'b0;
   logic [MW-1:0] opm [4];
   logic [2:0]    op [4];
   logic [MW-1:0] mpm [4];
   logic [DP:0]   msv [4];
   logic [MW-1:0] npm [4];
   logic [DP:0]   nsv [4];
   logic [1:0]    pa, pb;
   logic          lu;
   int            ma, mb;

   always #5 clk = ~clk;

   viterbi_ctrl #(.FRAME_LEN(FL), .TAIL(TL), .DEPTH(DP), .MW(MW)) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start),
      .sym_valid(sym_valid), .sym_in(sym_in), .sym_ready(sym_ready),
      .acs_en(acs_en), .acs_sym(acs_sym), .acs_erase(acs_erase),
      .norm_en(norm_en), .pm0(pm0), .pm1(pm1), .pm2(pm2), .pm3(pm3),
      .p0(p0), .p1(p1), .p2(p2), .p3(p3), .dec_valid(dec_valid),
      .dec_bit(dec_bit), .frame_done(frame_done), .busy(busy)
   );

   function automatic logic [1:0] enc(input logic [1:0] st,
                                      input logic u);
      return {u ^ st[1] ^ st[0], u ^ st[0]};
   endfunction

   function automatic int bmet(input logic [1:0] ps, input logic u,
                               input logic [1:0] s, input logic er);
      logic [1:0] d;
      d = s ^ enc(ps, u);
      return er ? 0 : int'(d[1]) + int'(d[0]);
   endfunction

   // Datapath model: state {u[n-1],u[n-2]}, survivor bit DP is u[n-DP].
   always @(posedge clk) begin
      if (mdl_init) begin
         mpm <= '{8'd0, 8'd32, 8'd32, 8'd32};
         msv <= '{default: '0};
      end else if (acs_en) begin
         for (int ns = 0; ns < 4; ns++) begin
            lu = ns[1];
            pa = {ns[0], 1'b0};
            pb = {ns[0], 1'b1};
            ma = int'(mpm[pa]) + bmet(pa, lu, acs_sym, acs_erase);
            mb = int'(mpm[pb]) + bmet(pb, lu, acs_sym, acs_erase);
            if (mb < ma) begin
               ma = mb;
               pa = pb;
            end
            if (norm_en) ma = ma - 128;
            npm[ns] = MW'(ma);
            nsv[ns] = {msv[pa][DP-1:0], lu};
         end
         mpm <= npm;
         msv <= nsv;
      end
   end

   assign pm0 = ovr ? opm[0] : mpm[0];
   assign pm1 = ovr ? opm[1] : mpm[1];
   assign pm2 = ovr ? opm[2] : mpm[2];
   assign pm3 = ovr ? opm[3] : mpm[3];
   assign p0  = ovr ? op[0] : msv[0][DP -: 3];
   assign p1  = ovr ? op[1] : msv[1][DP -: 3];
   assign p2  = ovr ? op[2] : msv[2][DP -: 3];
   assign p3  = ovr ? op[3] : msv[3][DP -: 3];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (acs_en) n_acs++;
         if (acs_en && acs_erase) n_era++;
         if (acs_en || norm_en)
            chk("norm_en", norm_en,
                acs_en & pm0[MW-1] & pm1[MW-1] & pm2[MW-1] & pm3[MW-1]);
         if (dec_valid) begin
            n_dec++;
            chk("dv_fd_overlap", frame_done, 0);
            if (exq.size() == 0) chk("dec_extra", exq.size(), 1);
            else chk("dec_bit", dec_bit, exq.pop_front());
         end
         if (frame_done) begin
            n_fd++;
            chk("fd_after_bits", n_dec, FL);
         end
      end
   end

   task automatic run_frame(input logic [31:0] data, input logic [31:0] expb,
                            input bit tog, input int fs_at, input int rst_at);
      logic [1:0] st;
      logic u;
      bit ok;
      int guard;
      st = 2'b00;
      n_dec = 0;
      n_acs = 0;
      n_era = 0;
      n_fd = 0;
      for (int k = 0; k < FL; k++) exq.push_back(expb[k]);
      mdl_init = 1'b1;
      frame_start = 1'b1;
      @(posedge clk); #1;
      mdl_init = 1'b0;
      frame_start = 1'b0;
      for (int i = 0; i < FL + TL; i++) begin
         u = (i < FL) ? data[i] : 1'b0;
         if (tog) begin
            sym_valid = 1'b0;
            @(posedge clk); #1;
         end
         sym_valid = 1'b1;
         sym_in = enc(st, u);
         frame_start = (i == fs_at);
         if (i == rst_at) begin
            #2 reset = 1'b0;
            #1;
            chk("rst_outs", {sym_ready, acs_en, acs_sym, acs_erase, norm_en,
                             dec_valid, dec_bit, frame_done, busy}, 0);
            sym_valid = 1'b0;
            frame_start = 1'b0;
            exq.delete();
            @(posedge clk); #1 reset = 1'b1;
            repeat (60) @(posedge clk);
            #1;
            chk("rst_no_fd", n_fd, 0);
            chk("rst_idle", busy, 0);
            return;
         end
         guard = 0;
         do begin
            ok = sym_ready;
            @(posedge clk); #1;
            guard++;
         end while (!ok && guard < 50);
         frame_start = 1'b0;
         if (!ok) chk("accept_timeout", ok, 1);
         st = {u, st[1]};
      end
      sym_valid = 1'b0;
      guard = 0;
      while (busy && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("busy_end", busy, 0);
      chk("n_dec", n_dec, FL);
      chk("n_acs", n_acs, FL + DP);
      chk("n_erase", n_era, DP - TL);
      chk("n_frame_done", n_fd, 1);
      chk("queue_empty", exq.size(), 0);
   endtask

   logic [31:0] expa;

   initial begin
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", {sym_ready, acs_en, acs_sym, acs_erase, norm_en,
                         dec_valid, dec_bit, frame_done, busy}, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("idle_busy", busy, 0);

      run_frame(32'h0, 32'h0, 1'b0, -1, -1);
      run_frame(32'hA5C3_0F17, 32'hA5C3_0F17, 1'b0, -1, -1);
      run_frame(32'hA5C3_0F17, 32'hA5C3_0F17, 1'b1, -1, -1);

      // Forced metrics: all MSBs set, min at state 1; flush outputs use state 0.
      for (int k = 0; k < FL; k++) expa[k] = (k + 1 + DP <= FL + TL);
      opm = '{8'h90, 8'h88, 8'hC0, 8'hF0};
      op  = '{3'b000, 3'b100, 3'b000, 3'b000};
      ovr = 1'b1;
      run_frame(32'h0, expa, 1'b0, -1, -1);
      opm = '{8'h10, 8'h40, 8'h10, 8'h50};
      op  = '{3'b100, 3'b000, 3'b000, 3'b000};
      run_frame(32'h0, 32'hFFFF_FFFF, 1'b0, -1, -1);
      ovr = 1'b0;

      run_frame(32'h3C96_E1D2, 32'h3C96_E1D2, 1'b0, 10, -1);
      run_frame(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, -1, 20);
      run_frame(32'h1234_5678, 32'h1234_5678, 1'b0, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
